// File: rtl/riscv_rf_pkg.sv
// Shared widths, zero-register constant and types for the RISC-V integer register file.
`timescale 1ns/1ps
package riscv_rf_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DEPTH  = 32;

  localparam logic [RF_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;
endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: entry select, x0 forced to zero,
// and same-cycle write forwarding when REGFILE_WRITE_BYPASS_EN is defined.
`timescale 1ns/1ps
module rf_read_port
  import riscv_rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic [ADDR_W-1:0]                     addr_i,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]      entries_i,
`ifdef REGFILE_WRITE_BYPASS_EN
  input  logic                                  rst_ni,
  input  logic                                  wr_en_i,
  input  logic [ADDR_W-1:0]                     wr_addr_i,
  input  logic [DATA_W-1:0]                     wr_data_i,
`endif
  output logic [DATA_W-1:0]                     data_o
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  // The zero check comes last so x0 reads zero even if a bypass would match.
  always_comb begin
    data_o = entries_i[addr_i];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_en_i && rst_ni && (wr_addr_i != ZeroAddr) && (addr_i == wr_addr_i)) begin
      data_o = wr_data_i;
    end
`endif
    if (addr_i == ZeroAddr) begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/riscv_reg_file.sv
// 32x32 RISC-V integer register file: two combinational read ports, one clocked write port.
// Optional same-cycle write forwarding on the read ports via `define REGFILE_WRITE_BYPASS_EN.
`timescale 1ns/1ps
module riscv_reg_file
  import riscv_rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int                Depth    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [Depth-1:0][DATA_W-1:0] regs_q;
  logic [Depth-1:0][DATA_W-1:0] regs_d;

  // Writes to x0 are dropped here so entry 0 never leaves its reset value.
  always_comb begin
    regs_d = regs_q;
    if (WE3 && (A3 != ZeroAddr)) begin
      regs_d[A3] = WD3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_read_port1 (
    .addr_i    (A1),
    .entries_i (regs_q),
`ifdef REGFILE_WRITE_BYPASS_EN
    .rst_ni    (rst),
    .wr_en_i   (WE3),
    .wr_addr_i (A3),
    .wr_data_i (WD3),
`endif
    .data_o    (RD1)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_read_port2 (
    .addr_i    (A2),
    .entries_i (regs_q),
`ifdef REGFILE_WRITE_BYPASS_EN
    .rst_ni    (rst),
    .wr_en_i   (WE3),
    .wr_addr_i (A3),
    .wr_data_i (WD3),
`endif
    .data_o    (RD2)
  );

endmodule

// File: tb/tb_riscv_reg_file.sv
// Scoreboard bench for riscv_reg_file; expected read data is queued by the stimulus
// and compared by an independent monitor. Honours REGFILE_WRITE_BYPASS_EN.
`timescale 1ns/1ps
module tb_riscv_reg_file;
  import riscv_rf_pkg::*;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  typedef struct {
    string    name;
    rf_data_t exp1;
    rf_data_t exp2;
    bit       chk2;
  } expect_t;

  logic     clk;
  logic     rst;
  rf_addr_t A1, A2, A3;
  rf_data_t WD3;
  logic     WE3;
  rf_data_t RD1, RD2;

  expect_t  sbQ[$];
  event     sampleEv;
  int       checks;
  int       errors;
  rf_data_t model[0:31];

  riscv_reg_file #(.DATA_W(RF_DATA_W), .ADDR_W(RF_ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .A1  (A1),
    .A2  (A2),
    .A3  (A3),
    .WD3 (WD3),
    .WE3 (WE3),
    .RD1 (RD1),
    .RD2 (RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: each sample strobe pops one expectation and compares both read ports.
  initial begin
    expect_t e;
    checks = 0;
    errors = 0;
    forever begin
      @(sampleEv);
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard-underflow: sample with empty queue, RD1=%h", RD1);
      end else begin
        e = sbQ.pop_front();
        checks++;
        if (RD1 !== e.exp1) begin
          errors++;
          $display("[TB] FAIL %s RD1: got %h expected %h", e.name, RD1, e.exp1);
        end
        if (e.chk2) begin
          checks++;
          if (RD2 !== e.exp2) begin
            errors++;
            $display("[TB] FAIL %s RD2: got %h expected %h", e.name, RD2, e.exp2);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input rf_addr_t a1, input rf_addr_t a2, input rf_addr_t a3,
                               input rf_data_t wd, input logic we);
    A1  = a1;
    A2  = a2;
    A3  = a3;
    WD3 = wd;
    WE3 = we;
  endtask

  task automatic checkOutput(input string name, input rf_data_t e1, input rf_data_t e2,
                             input bit chk2);
    expect_t e;
    #1;
    e.name = name;
    e.exp1 = e1;
    e.exp2 = e2;
    e.chk2 = chk2;
    sbQ.push_back(e);
    -> sampleEv;
    #1;
  endtask

  // Drives a write at the falling edge, lets the rising edge take it, returns at the next falling edge.
  task automatic writeReg(input rf_addr_t addr, input rf_data_t data);
    applyStimulus(A1, A2, addr, data, 1'b1);
    @(posedge clk);
    if (rst && addr != 5'd0) model[addr] = data;
    @(negedge clk);
    WE3 = 1'b0;
  endtask

  initial begin
    rf_data_t val;
    for (int i = 0; i < 32; i++) model[i] = '0;
    rst = 1'b0;
    applyStimulus(5'd0, 5'd0, 5'd0, '0, 1'b0);

    // Reset held with the clock running and writes attempted: everything reads zero.
    #4;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(5'(i), 5'(31 - i), 5'(i), 32'hFFFF_FFFF, 1'b1);
      checkOutput("reset-sweep", '0, '0, 1'b1);
    end
    @(negedge clk);
    applyStimulus(5'd0, 5'd0, 5'd0, '0, 1'b0);
    rst = 1'b1;
    applyStimulus(5'd31, 5'd20, 5'd0, '0, 1'b0);
    checkOutput("post-reset-untouched", '0, '0, 1'b1);

    // Sequential writes to 0..9, then a crossed sweep of both read ports.
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      val = $urandom;
      if (val == '0) val = 32'h1;
      writeReg(5'(i), val);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(5'(i), 5'(10 - i), 5'd0, '0, 1'b0);
      checkOutput("readback", model[i], model[10 - i], 1'b1);
    end

    // x0 ignores writes.
    @(negedge clk);
    writeReg(5'd0, 32'hDEAD_BEEF);
    applyStimulus(5'd0, 5'd0, 5'd0, '0, 1'b0);
    checkOutput("zero-reg", 32'h0, 32'h0, 1'b1);

    // WE3=0 leaves the entry unchanged.
    @(negedge clk);
    writeReg(5'd5, 32'hA5A5_A5A5);
    applyStimulus(5'd5, 5'd5, 5'd5, 32'h1234_5678, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("write-enable-low", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1);

    // Collision: old value before the edge (forwarded value with bypass), new after.
    @(negedge clk);
    writeReg(5'd7, 32'h1);
    applyStimulus(5'd7, 5'd5, 5'd7, 32'h2, 1'b1);
    checkOutput("collision-before-edge", Bypass ? 32'h2 : 32'h1, 32'hA5A5_A5A5, 1'b1);
    @(posedge clk);
    model[7] = 32'h2;
    checkOutput("collision-after-edge", 32'h2, 32'hA5A5_A5A5, 1'b1);
    @(negedge clk);
    WE3 = 1'b0;

    // Forwarding must never expose a write aimed at x0.
    applyStimulus(5'd0, 5'd7, 5'd0, 32'h5555_AAAA, 1'b1);
    checkOutput("x0-no-forward", 32'h0, 32'h2, 1'b1);
    @(negedge clk);
    WE3 = 1'b0;

    // Both ports on the same entry.
    writeReg(5'd3, 32'hCAFE_F00D);
    applyStimulus(5'd3, 5'd3, 5'd0, '0, 1'b0);
    checkOutput("dual-port-same", 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);

    // Asynchronous clear mid-run: visible before any clock edge, overrides a pending write.
    @(negedge clk);
    applyStimulus(5'd3, 5'd7, 5'd9, 32'h7777_7777, 1'b1);
    rst = 1'b0;
    checkOutput("async-clear-no-edge", '0, '0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(5'(i), 5'(31 - i), 5'd9, 32'h7777_7777, 1'b1);
      checkOutput("async-clear-sweep", '0, '0, 1'b1);
    end
    @(negedge clk);
    applyStimulus(5'd9, 5'd3, 5'd0, '0, 1'b0);
    rst = 1'b1;
    checkOutput("after-second-reset", '0, '0, 1'b1);

    // First write after release lands on the first rising edge.
    writeReg(5'd12, 32'h0BAD_CAFE);
    applyStimulus(5'd12, 5'd9, 5'd0, '0, 1'b0);
    checkOutput("first-write-after-reset", 32'h0BAD_CAFE, 32'h0, 1'b1);

    #2;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard-drain: %0d entries left, expected 0", sbQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
